// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter that shares one single-port 32-bit RAM between NUM_REQ masters.
// Define SP_RAM_ARB_LOCK_EN to add the bus-lock FSM (bounded by MAX_LOCK consecutive grants).
module sp_ram_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 15,
    parameter int MAX_LOCK   = 16
) (
    input  logic                          clk,
    input  logic                          rstn_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            lock_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_REQ-1:0]            we_i,
    input  logic [NUM_REQ*4-1:0]          be_i,
    input  logic [NUM_REQ*32-1:0]         wdata_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            rvalid_o,
    output logic [31:0]                   rdata_o,
    output logic                          ram_en_o,
    output logic [ADDR_WIDTH-1:0]         ram_addr_o,
    output logic [31:0]                   ram_wdata_o,
    output logic                          ram_we_o,
    output logic [3:0]                    ram_be_o,
    input  logic [31:0]                   ram_rdata_i
);
    localparam int PW = (NUM_REQ > 2) ? 2 : 1;

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
        return (i == PW'(NUM_REQ - 1)) ? '0 : i + PW'(1);
    endfunction

    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] rvalid_q;
    logic [NUM_REQ-1:0] elig;
    logic [PW-1:0]      base_ptr;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_any;
    logic [PW-1:0]      gnt_idx;

    // first eligible master scanning upward from base_ptr, wrapping at NUM_REQ
    always_comb begin
        int k;
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        k       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(base_ptr) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (!gnt_any && elig[k]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(k);
            end
        end
        if (gnt_any) gnt[gnt_idx] = 1'b1;
    end

    assign rr_ptr_d = gnt_any ? next_idx(gnt_idx) : base_ptr;

    always_comb begin
        ram_en_o    = gnt_any;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        if (gnt_any) begin
            ram_addr_o  = addr_i[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            ram_wdata_o = wdata_i[int'(gnt_idx)*32 +: 32];
            ram_we_o    = we_i[gnt_idx];
            ram_be_o    = be_i[int'(gnt_idx)*4 +: 4];
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            rr_ptr_q <= '0;
            rvalid_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            rvalid_q <= gnt;
        end
    end

    assign gnt_o    = gnt;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = ram_rdata_i;

`ifdef SP_RAM_ARB_LOCK_EN
    localparam int CW = $clog2(MAX_LOCK + 1);

    typedef enum logic {S_IDLE, S_LOCKED} state_e;

    state_e         state_q, state_d;
    logic [PW-1:0]  owner_q, owner_d;
    logic [CW-1:0]  lock_cnt_q, lock_cnt_d;
    logic           locked, forced, release_now;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= S_IDLE;
            owner_q    <= '0;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // release takes effect in the same cycle, so arbitration is already round robin
    always_comb begin
        locked      = (state_q == S_LOCKED);
        forced      = (lock_cnt_q == CW'(MAX_LOCK));
        release_now = locked && (!lock_i[owner_q] || forced);
        elig        = req_i;
        base_ptr    = rr_ptr_q;
        if (locked && !release_now)
            elig = req_i & (NUM_REQ'(1) << owner_q);
        else if (release_now && forced)
            base_ptr = next_idx(owner_q);
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        if (locked && !release_now) begin
            if (gnt_any) lock_cnt_d = lock_cnt_q + CW'(1);
        end else begin
            state_d    = S_IDLE;
            lock_cnt_d = '0;
            if (gnt_any && lock_i[gnt_idx]) begin
                state_d    = S_LOCKED;
                owner_d    = gnt_idx;
                lock_cnt_d = CW'(1);
            end
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^lock_i;
    assign elig        = req_i;
    assign base_ptr    = rr_ptr_q;
`endif

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed bench for sp_ram_arbiter: RAM model, spec-level reference model checked every cycle,
// plus literal expectations from hand-worked scenarios.
module tb_sp_ram_arbiter;
    localparam int NR   = 2;
    localparam int AW   = 15;
    localparam int MAXL = 4;

    logic              clk = 1'b0;
    logic              rstn_i = 1'b1;
    logic [NR-1:0]     req_i = '0;
    logic [NR-1:0]     lock_i = '0;
    logic [NR*AW-1:0]  addr_i = '0;
    logic [NR-1:0]     we_i = '0;
    logic [NR*4-1:0]   be_i = '0;
    logic [NR*32-1:0]  wdata_i = '0;
    logic [NR-1:0]     gnt_o, rvalid_o;
    logic [31:0]       rdata_o;
    logic              ram_en_o, ram_we_o;
    logic [AW-1:0]     ram_addr_o;
    logic [31:0]       ram_wdata_o;
    logic [3:0]        ram_be_o;
    logic [31:0]       ram_rdata_i = '0;

    int total = 0;
    int bad   = 0;

    sp_ram_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .MAX_LOCK(MAXL)) dut (
        .clk(clk), .rstn_i(rstn_i), .req_i(req_i), .lock_i(lock_i), .addr_i(addr_i),
        .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
        .ram_rdata_i(ram_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // single-port RAM with 1-cycle read latency
    logic [31:0] mem [int];
    always @(posedge clk) begin
        logic [31:0] w;
        int idx;
        if (ram_en_o) begin
            idx = int'(ram_addr_o[AW-1:2]);
            w   = mem.exists(idx) ? mem[idx] : 32'h0;
            if (ram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be_o[b]) w[8*b +: 8] = ram_wdata_o[8*b +: 8];
                mem[idx] = w;
            end else begin
                ram_rdata_i <= w;
            end
        end
    end

    // reference model: spec rules applied once per cycle, checked mid-cycle
    int          m_ptr = 0, m_owner = -1, m_cnt = 0;
    logic [NR-1:0] m_prev = '0;
    bit          m_prev_read = 0;
    logic [31:0] m_prev_data = '0;
    logic [31:0] sh [int];

    always @(negedge clk) begin
        int eg, base, k, idx;
        bit restr;
        logic [NR-1:0] eg_oh;
        logic [31:0] w;
        if (!rstn_i) begin
            chk("rst_rvalid", rvalid_o, '0);
            m_ptr = 0; m_owner = -1; m_cnt = 0; m_prev = '0; m_prev_read = 0;
        end else begin
            base  = m_ptr;
            restr = 0;
`ifdef SP_RAM_ARB_LOCK_EN
            if (m_owner >= 0) begin
                if (!lock_i[m_owner]) m_owner = -1;
                else if (m_cnt == MAXL) begin base = (m_owner + 1) % NR; m_owner = -1; end
                else restr = 1;
            end
`endif
            eg = -1;
            if (restr) begin
                if (req_i[m_owner]) eg = m_owner;
            end else begin
                for (int i = 0; i < NR; i++) begin
                    k = (base + i) % NR;
                    if (eg < 0 && req_i[k]) eg = k;
                end
            end
            eg_oh = '0;
            if (eg >= 0) eg_oh[eg] = 1'b1;
            chk("m_gnt", gnt_o, eg_oh);
            chk("m_ram_en", ram_en_o, (eg >= 0));
            if (eg >= 0) begin
                chk("m_ram_addr", ram_addr_o, addr_i[eg*AW +: AW]);
                chk("m_ram_we", ram_we_o, we_i[eg]);
                chk("m_ram_be", ram_be_o, be_i[eg*4 +: 4]);
                chk("m_ram_wdata", ram_wdata_o, wdata_i[eg*32 +: 32]);
            end else begin
                chk("m_ram_idle", {ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o}, '0);
            end
            chk("m_rvalid", rvalid_o, m_prev);
            if (m_prev_read) chk("m_rdata", rdata_o, m_prev_data);
`ifdef SP_RAM_ARB_LOCK_EN
            if (restr) begin
                if (eg >= 0) m_cnt++;
            end else if (eg >= 0 && lock_i[eg]) begin
                m_owner = eg; m_cnt = 1;
            end else begin
                m_cnt = 0;
            end
`endif
            m_prev      = eg_oh;
            m_prev_read = 0;
            if (eg >= 0) begin
                idx = int'(addr_i[eg*AW+2 +: AW-2]);
                w   = sh.exists(idx) ? sh[idx] : 32'h0;
                if (we_i[eg]) begin
                    for (int b = 0; b < 4; b++)
                        if (be_i[eg*4+b]) w[8*b +: 8] = wdata_i[eg*32+8*b +: 8];
                    sh[idx] = w;
                end else begin
                    m_prev_read = 1;
                    m_prev_data = w;
                end
                m_ptr = (eg + 1) % NR;
            end else begin
                m_ptr = base;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic setm(input int k, input bit r, input bit w, input logic [AW-1:0] a,
                        input logic [3:0] b, input logic [31:0] d, input bit l);
        req_i[k] = r;
        we_i[k]  = w;
        lock_i[k] = l;
        addr_i[k*AW +: AW] = a;
        be_i[k*4 +: 4]     = b;
        wdata_i[k*32 +: 32] = d;
    endtask

    task automatic idle_all;
        req_i = '0; lock_i = '0; we_i = '0;
    endtask

    initial begin
        // 1: reset then quiet bus
        #1 rstn_i = 1'b0;
        repeat (3) tick;
        rstn_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("idle_gnt", gnt_o, '0);
            chk("idle_rvalid", rvalid_o, '0);
            chk("idle_ram_en", ram_en_o, 1'b0);
            tick;
        end

        // 2: m0 write then read back
        setm(0, 1, 1, 15'h10, 4'hF, 32'hDEADBEEF, 0);
        #1 chk("t2_wr_gnt", gnt_o, 2'b01);
        tick;
        chk("t2_wr_rvalid", rvalid_o, 2'b01);
        setm(0, 1, 0, 15'h10, 4'hF, 32'h0, 0);
        #1 chk("t2_rd_gnt", gnt_o, 2'b01);
        tick;
        chk("t2_rd_rvalid", rvalid_o, 2'b01);
        chk("t2_rdata", rdata_o, 32'hDEADBEEF);
        idle_all;
        tick;

        // 4: m1 alone, full write, partial write, two reads
        setm(1, 1, 1, 15'h20, 4'hF, 32'hFFFFFFFF, 0);
        #1 chk("t4_gnt0", gnt_o, 2'b10);
        tick;
        setm(1, 1, 1, 15'h20, 4'h3, 32'h0000AAAA, 0);
        #1 chk("t4_gnt1", gnt_o, 2'b10);
        tick;
        setm(1, 1, 0, 15'h20, 4'hF, 32'h0, 0);
        #1 chk("t4_gnt2", gnt_o, 2'b10);
        tick;
        chk("t4_rvalid", rvalid_o, 2'b10);
        chk("t4_rdata", rdata_o, 32'hFFFFAAAA);
        #1 chk("t4_gnt3", gnt_o, 2'b10);
        tick;
        idle_all;
        tick;

        // 3: both request from rr_ptr=0, strict alternation
        setm(0, 1, 0, 15'h10, 4'hF, 32'h0, 0);
        setm(1, 1, 0, 15'h20, 4'hF, 32'h0, 0);
        for (int i = 0; i < 6; i++) begin
            #1 chk($sformatf("t3_gnt%0d", i), gnt_o, (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i > 0) chk($sformatf("t3_rvalid%0d", i), rvalid_o, (i % 2 == 0) ? 2'b10 : 2'b01);
            tick;
        end
        idle_all;
        chk("t3_rvalid_last", rvalid_o, 2'b10);
        tick;

        // 5: reset while a read response is out
        setm(0, 1, 0, 15'h10, 4'hF, 32'h0, 0);
        #1 chk("t5_gnt", gnt_o, 2'b01);
        tick;
        chk("t5_rvalid_pre", rvalid_o, 2'b01);
        idle_all;
        rstn_i = 1'b0;
        #1 chk("t5_rvalid_async", rvalid_o, 2'b00);
        tick;
        tick;
        rstn_i = 1'b1;
        setm(0, 1, 0, 15'h10, 4'hF, 32'h0, 0);
        setm(1, 1, 0, 15'h20, 4'hF, 32'h0, 0);
        #1 chk("t5_ptr_reset", gnt_o, 2'b01);
        tick;
        idle_all;
        tick;

`ifdef SP_RAM_ARB_LOCK_EN
        // 6a: lock held to the MAX_LOCK limit, then forced release to m1
        rstn_i = 1'b0;
        tick;
        rstn_i = 1'b1;
        setm(0, 1, 0, 15'h10, 4'hF, 32'h0, 1);
        setm(1, 1, 0, 15'h20, 4'hF, 32'h0, 0);
        for (int i = 0; i < 5; i++) begin
            #1 chk($sformatf("t6a_gnt%0d", i), gnt_o, (i < 4) ? 2'b01 : 2'b10);
            tick;
        end
        idle_all;
        tick;
        // 6b: lock dropped after two grants
        rstn_i = 1'b0;
        tick;
        rstn_i = 1'b1;
        setm(0, 1, 0, 15'h10, 4'hF, 32'h0, 1);
        setm(1, 1, 0, 15'h20, 4'hF, 32'h0, 0);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) lock_i[0] = 1'b0;
            #1 chk($sformatf("t6b_gnt%0d", i), gnt_o, (i < 2) ? 2'b01 : 2'b10);
            tick;
        end
        idle_all;
        tick;
`endif

        tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
